// File: rtl/a1_sweep_pkg.sv
// Shared types and constants for the A1 exhaustive sweep controller.
package a1_sweep_pkg;

  localparam int unsigned NUM_IN_DEF  = 3;
  localparam int unsigned NUM_VEC_DEF = 1 << NUM_IN_DEF;
  localparam int unsigned CNT_W       = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/a1_settle_timer.sv
// Loadable down-counter that times how long a vector is held before f is sampled.
module a1_settle_timer
  import a1_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt;

  // Load has priority; the count parks at zero rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/a1_sweep_ctrl.sv
// Drives every input vector into the A1 block, captures f and grades it against a golden table.
// Optional build macro: A1_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module a1_sweep_ctrl
  import a1_sweep_pkg::*;
#(
  parameter int unsigned NUM_IN        = NUM_IN_DEF,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [(1<<NUM_IN)-1:0] expected,
  output logic [NUM_IN-1:0]     vec_out,
  input  logic                  f_in,
  output logic                  busy,
  output logic                  done,
  output logic [(1<<NUM_IN)-1:0] table_out,
  output logic                  pass,
  output logic [NUM_IN:0]       mismatch_cnt,
  output logic [NUM_IN-1:0]     first_fail_idx
);

  localparam int unsigned NUM_VEC = 1 << NUM_IN;
  localparam int unsigned MM_W    = NUM_IN + 1;

  state_t state, state_nx;

  logic [NUM_VEC-1:0] exp_q;
  logic [NUM_VEC-1:0] exp_d;
  logic [NUM_IN-1:0]  vec_d;
  logic [NUM_VEC-1:0] table_d;
  logic [MM_W-1:0]    mm_d;
  logic [NUM_IN-1:0]  ff_d;
  logic               pass_d;
  logic               busy_d;
  logic               done_d;

  logic mismatch_c;
  logic last_c;
  logic tmr_load_c;
  logic tmr_zero_c;

  assign mismatch_c = (f_in != exp_q[vec_out]);
  assign last_c     = (vec_out == NUM_IN'(NUM_VEC - 1));

  a1_settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_c),
    .load_val (CNT_W'(SETTLE_CYCLES - 1)),
    .en       (state == SETTLE),
    .zero_c   (tmr_zero_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (start) state_nx = SETTLE;
      SETTLE: if (tmr_zero_c) state_nx = SAMPLE;
`ifdef A1_SWEEP_STOP_ON_FAIL_EN
      SAMPLE: state_nx = (last_c || mismatch_c) ? DONE : SETTLE;
`else
      SAMPLE: state_nx = last_c ? DONE : SETTLE;
`endif
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of every registered output; results hold unless a sweep updates them.
  always_comb begin
    exp_d      = exp_q;
    vec_d      = vec_out;
    table_d    = table_out;
    mm_d       = mismatch_cnt;
    ff_d       = first_fail_idx;
    pass_d     = pass;
    done_d     = 1'b0;
    busy_d     = (state_nx != IDLE);
    tmr_load_c = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          exp_d      = expected;
          vec_d      = '0;
          table_d    = '0;
          mm_d       = '0;
          ff_d       = '0;
          pass_d     = 1'b0;
          tmr_load_c = 1'b1;
        end
      end
      SAMPLE: begin
        table_d[vec_out] = f_in;
        if (mismatch_c) begin
          mm_d = mismatch_cnt + MM_W'(1);
          if (mismatch_cnt == '0) ff_d = vec_out;
        end
        if (state_nx == SETTLE) begin
          vec_d      = vec_out + NUM_IN'(1);
          tmr_load_c = 1'b1;
        end
        if (state_nx == DONE) begin
          done_d = 1'b1;
          pass_d = (mm_d == '0);
        end
      end
      DONE: vec_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q          <= '0;
      vec_out        <= '0;
      table_out      <= '0;
      mismatch_cnt   <= '0;
      first_fail_idx <= '0;
      pass           <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      exp_q          <= exp_d;
      vec_out        <= vec_d;
      table_out      <= table_d;
      mismatch_cnt   <= mm_d;
      first_fail_idx <= ff_d;
      pass           <= pass_d;
      busy           <= busy_d;
      done           <= done_d;
    end
  end

endmodule

// File: doc/a1_sweep_ctrl.md
Name: a1_sweep_ctrl

Overview:
Sequencer that exhaustively exercises the 3-input combinational A1 block in hardware. On a start pulse it drives all 2^NUM_IN input vectors onto {a,b,c} in ascending order. After each vector it waits a settle interval, samples f, and builds a captured truth table. It then compares that table against an expected table, reports pass/fail, mismatch count and first failing index, and sits between a host/self-test controller and the A1 instance.

Parameters:
NUM_IN, 3, number of A1 inputs; vector count NUM_VEC = 2^NUM_IN; a is MSB of vec_out.
SETTLE_CYCLES, 2, cycles vec_out is held stable before f is sampled; legal range 1..255.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin a sweep; honoured only in IDLE
expected  input  NUM_VEC  golden truth table, bit i = f for vector i; captured on accepted start
vec_out  output  NUM_IN  drives {a,b,c} of A1
f_in  input  1  f from A1
busy  output  1  high from cycle after accepted start until DONE state exits
done  output  1  one-cycle pulse, results valid from this cycle
table_out  output  NUM_VEC  captured truth table
pass  output  1  table_out == captured expected; valid with/after done
mismatch_cnt  output  NUM_IN+1  number of mismatching vectors, 0..NUM_VEC
first_fail_idx  output  NUM_IN  lowest mismatching index; 0 when pass

Behaviour:
- Reset (sync, rst=1 at a clock edge): state=IDLE; vec_out=0, busy=0, done=0, table_out=0, pass=0, mismatch_cnt=0, first_fail_idx=0. Reset mid-sweep aborts immediately; no done pulse.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: start=1 -> capture expected, idx=0, vec_out=0, clear table_out/mismatch_cnt/first_fail_idx/pass, settle counter=SETTLE_CYCLES-1, go SETTLE. Otherwise hold all results from the last sweep.
- SETTLE: lasts exactly SETTLE_CYCLES cycles; vec_out is stable. Counter decrements; at 0 go SAMPLE.
- SAMPLE (1 cycle): table_out[idx]<=f_in.
  - If f_in != expected[idx]: mismatch_cnt++. On the first mismatch of the sweep, first_fail_idx<=idx.
  - If idx==NUM_VEC-1: go DONE.
  - Otherwise idx++, vec_out<=idx+1, reload counter, go SETTLE.
- DONE (1 cycle): done=1, pass=(mismatch_cnt==0) registered, busy=0 next cycle, go IDLE.
- Latency: start accepted at edge T -> done high in cycle T+NUM_VEC*(SETTLE_CYCLES+1)+1. Defaults give T+25.
- start while not IDLE: ignored, no queuing. start in DONE cycle is ignored. start held high re-triggers on the first IDLE cycle.
- expected changes during a sweep have no effect.
- idx wraps never: the sweep terminates at NUM_VEC-1. mismatch_cnt is sized to hold NUM_VEC without overflow.
- vec_out returns to 0 in IDLE after DONE.

Optional Feature:
Macro A1_SWEEP_STOP_ON_FAIL_EN.
- Defined: the first mismatching SAMPLE goes directly to DONE. table_out bits above the failing idx remain 0, mismatch_cnt=1, pass=0, and latency shrinks accordingly.
- Undefined: every sweep covers all NUM_VEC vectors regardless of mismatches.

Decomposition:
- Package a1_sweep_pkg holds the state encoding (IDLE=0, SETTLE=1, SAMPLE=2, DONE=3), NUM_IN/NUM_VEC defaults, and the counter width constant (8).
- One sub-module, a1_settle_timer: a loadable down-counter with load/value/zero flag, instantiated once.

Test Plan:
- Reset then idle 5 cycles -> all outputs 0, busy=0, done never asserted.
- A1 model f=majority(a,b,c), expected=8'hE8, start at T -> vec_out steps 0..7, each held 3 cycles; done at T+25, table_out=8'hE8, pass=1, mismatch_cnt=0.
- Same model with expected=8'hE9 -> table_out=8'hE8, pass=0, mismatch_cnt=1, first_fail_idx=0. With A1_SWEEP_STOP_ON_FAIL_EN: done at T+4, table_out=8'h00.
- expected=8'h17 against majority (all bits differ) -> mismatch_cnt=8, first_fail_idx=0, pass=0; counter does not wrap.
- start pulsed at T+10 mid-sweep, and expected changed at T+5 -> no restart; results identical to the single-start run, single done at T+25.
- rst=1 at T+12 mid-sweep -> next cycle IDLE, vec_out=0, table_out=0, no done. A new start then yields a normal full sweep.
